// File: rtl/compressor_block_sequencer_if.sv
// compressor_block_sequencer_if
//   Bundles the operand stream, the shift-register and compressor taps, and
//   the result port of compressor_block_sequencer.
//   Ports (signals):
//     in_valid/in_ready/in_data     operand word stream (master -> sequencer)
//     sr_data                       serial column bits to the shift register
//     cmp_dst                       compressor result bus
//     res_valid/res_ready           result handshake
//     res_value/res_expected        captured sum and locally accumulated sum
//     res_mismatch, err_count       comparison flag and mismatch counter
//   Modports: master = stimulus/compressor side, slave = sequencer.
interface compressor_block_sequencer_if #(
    parameter int N_COL = 30,
    parameter int OUT_W = 35
);
    logic             in_valid;
    logic             in_ready;
    logic [N_COL-1:0] in_data;
    logic [N_COL-1:0] sr_data;
    logic [OUT_W-1:0] cmp_dst;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_value;
    logic [OUT_W-1:0] res_expected;
    logic             res_mismatch;
    logic [15:0]      err_count;

    modport master (
        output in_valid, in_data, cmp_dst, res_ready,
        input  in_ready, sr_data, res_valid, res_value, res_expected,
               res_mismatch, err_count
    );

    modport slave (
        input  in_valid, in_data, cmp_dst, res_ready,
        output in_ready, sr_data, res_valid, res_value, res_expected,
               res_mismatch, err_count
    );
endinterface

// File: rtl/compressor_block_sequencer.sv
// compressor_block_sequencer
//   Buffers one block of DEPTH column words, streams it into the free-running
//   shift-register front end of the column compressor on DEPTH back-to-back
//   cycles, then captures the compressor sum, checks it against a locally
//   accumulated sum and offers the result on a valid/ready port.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   compressor_block_sequencer_if.slave (stream in, sr_data out,
//           cmp_dst in, result port out)
//   Optional feature: define ERR_CNT_EN to enable the saturating 16-bit
//   mismatch counter on err_count; otherwise err_count is tied to zero.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_LOAD   | accept words into the block buffer, accumulate their sum
//   S_SHIFT  | drive buffer word scnt onto sr_data, one word per cycle
//   S_WAIT   | block fully in the shift register; wait LATENCY cycles
//   S_RESULT | hold the captured result until res_ready
module compressor_block_sequencer #(
    parameter int N_COL   = 30,
    parameter int DEPTH   = 30,
    parameter int OUT_W   = 35,
    parameter int LATENCY = 0
) (
    input logic                          clk,
    input logic                          rst,
    compressor_block_sequencer_if.slave  bus
);
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

    typedef enum logic [1:0] {S_LOAD, S_SHIFT, S_WAIT, S_RESULT} state_t;

    state_t           state;
    logic [CW-1:0]    wcnt;
    logic [CW-1:0]    scnt;
    logic [CW-1:0]    wt;
    logic [OUT_W-1:0] acc;
    logic [N_COL-1:0] blk_mem [DEPTH];

    logic             in_ready_q;
    logic [N_COL-1:0] sr_q;
    logic             res_valid_q;
    logic [OUT_W-1:0] res_value_q;
    logic [OUT_W-1:0] res_expected_q;
    logic             res_mismatch_q;

    logic             accept;
    logic             capture;
    logic             capture_bad;

    assign accept      = (state == S_LOAD) && bus.in_valid && in_ready_q;
    assign capture     = (state == S_WAIT) && (wt == LAT_C);
    assign capture_bad = capture && (bus.cmp_dst != acc);

    // Data storage only; no reset needed since every slot is written before use.
    always_ff @(posedge clk) begin
        if (accept) blk_mem[wcnt] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_LOAD;
            wcnt           <= '0;
            scnt           <= '0;
            wt             <= '0;
            acc            <= '0;
            in_ready_q     <= 1'b0;
            sr_q           <= '0;
            res_valid_q    <= 1'b0;
            res_value_q    <= '0;
            res_expected_q <= '0;
            res_mismatch_q <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        acc  <= acc + OUT_W'(bus.in_data);
                        wcnt <= wcnt + CW'(1);
                        if (wcnt == LAST) begin
                            state      <= S_SHIFT;
                            scnt       <= '0;
                            in_ready_q <= 1'b0;
                            // sr_data is registered, so word 0 is launched here;
                            // with DEPTH==1 it is the word being accepted now.
                            sr_q       <= (wcnt == '0) ? bus.in_data : blk_mem[0];
                        end
                    end
                end
                S_SHIFT: begin
                    if (scnt == LAST) begin
                        state <= S_WAIT;
                        wt    <= '0;
                        sr_q  <= '0;
                    end else begin
                        scnt <= scnt + CW'(1);
                        sr_q <= blk_mem[scnt + CW'(1)];
                    end
                end
                S_WAIT: begin
                    if (capture) begin
                        state          <= S_RESULT;
                        res_valid_q    <= 1'b1;
                        res_value_q    <= bus.cmp_dst;
                        res_expected_q <= acc;
                        res_mismatch_q <= capture_bad;
                    end else begin
                        wt <= wt + CW'(1);
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        state       <= S_LOAD;
                        res_valid_q <= 1'b0;
                        acc         <= '0;
                        wcnt        <= '0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

`ifdef ERR_CNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (capture_bad && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = 16'h0;
`endif

    assign bus.in_ready     = in_ready_q;
    assign bus.sr_data      = sr_q;
    assign bus.res_valid    = res_valid_q;
    assign bus.res_value    = res_value_q;
    assign bus.res_expected = res_expected_q;
    assign bus.res_mismatch = res_mismatch_q;
endmodule
